// File: rtl/loss_unit.sv
// rtl/loss_unit.sv - per-sample error accumulator (squared error; |diff| when LOSS_UNIT_ABS_ERR_EN is defined)
module loss_unit #(
   parameter int BITS  = 16,
   parameter int FRAC  = 8,
   parameter int N_OUT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            out_valid,
   input  logic [BITS-1:0] out_data,
   input  logic [BITS-1:0] target,
   output logic            in_ready,
   output logic [BITS-1:0] Error,
   output logic            S_Error,
   output logic            busy
);

   localparam int ACC_W  = BITS + 8;
   localparam int TERM_W = 2 * BITS + 2;
   localparam int SUM_W  = TERM_W + 1;
   localparam int CNT_W  = $clog2(N_OUT + 1);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_OUT - 1);
   localparam logic [ACC_W-1:0] ERR_MAX = {{(ACC_W-BITS+1){1'b0}}, {(BITS-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t            state, state_n;
   logic [ACC_W-1:0]  acc, acc_n, acc_add, err_clip;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [BITS-1:0]   error_n;
   logic signed [BITS:0] diff;
   logic [TERM_W-1:0] term;
   logic [SUM_W-1:0]  sum;

   assign diff = $signed({out_data[BITS-1], out_data}) - $signed({target[BITS-1], target});

`ifdef LOSS_UNIT_ABS_ERR_EN
   logic [BITS:0] mag;
   assign mag  = diff[BITS] ? (~diff + 1'b1) : diff;
   assign term = {{(TERM_W-BITS-1){1'b0}}, mag};
`else
   logic signed [TERM_W-1:0] dx, sq;
   assign dx   = {{(TERM_W-BITS-1){diff[BITS]}}, diff};
   assign sq   = dx * dx;
   assign term = $unsigned(sq) >> FRAC;
`endif

   // Wide sum so saturation can be detected before truncating to the accumulator.
   assign sum      = {{(SUM_W-ACC_W){1'b0}}, acc} + {1'b0, term};
   assign acc_add  = (sum > {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}}) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
   assign err_clip = (acc_add > ERR_MAX) ? ERR_MAX : acc_add;

   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_n   = cnt;
      error_n = Error;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = ACCUM;
               acc_n   = '0;
               cnt_n   = '0;
            end
         end
         ACCUM: begin
            if (start) begin
               acc_n = '0;
               cnt_n = '0;
            end else if (out_valid) begin
               acc_n = acc_add;
               cnt_n = cnt + 1'b1;
               if (cnt == LAST) begin
                  state_n = DONE;
                  error_n = err_clip[BITS-1:0];
               end
            end
         end
         DONE: begin
            if (start) begin
               state_n = ACCUM;
               acc_n   = '0;
               cnt_n   = '0;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         Error <= '0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         cnt   <= cnt_n;
         Error <= error_n;
      end
   end

   assign in_ready = (state == ACCUM);
   assign busy     = (state != IDLE);
   assign S_Error  = (state == DONE);

endmodule

// File: tb/tb_loss_unit.sv
// tb/tb_loss_unit.sv - randomized self-checking bench for loss_unit against an arithmetic error model
module tb_loss_unit;

   logic        clk = 1'b0;
   logic        rst, start, out_valid;
   logic [15:0] out_data, target;
   logic        in_ready, S_Error, busy;
   logic [15:0] Error;

   int tests = 0;
   int fails = 0;
   int pulses = 0;
   logic [15:0] bo[8];
   logic [15:0] bt[8];

   loss_unit #(.BITS(16), .FRAC(8), .N_OUT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .out_valid(out_valid),
      .out_data(out_data), .target(target), .in_ready(in_ready),
      .Error(Error), .S_Error(S_Error), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (S_Error === 1'b1) pulses++;

   function automatic longint term_of(logic [15:0] o, logic [15:0] t);
      longint d;
      d = longint'($signed(o)) - longint'($signed(t));
`ifdef LOSS_UNIT_ABS_ERR_EN
      return (d < 0) ? -d : d;
`else
      return (d * d) / 256;
`endif
   endfunction

   function automatic logic [15:0] model_err(int first, int n);
      longint a = 0;
      for (int i = first; i < first + n; i++) begin
         a = a + term_of(bo[i], bt[i]);
         if (a > 64'hFF_FFFF) a = 64'hFF_FFFF;
      end
      if (a > 32767) a = 32767;
      return 16'(a);
   endfunction

   function automatic logic [15:0] rnd_word();
      int sel = $urandom_range(0, 2);
      if (sel == 0) return 16'($urandom);
      if (sel == 1) return 16'($urandom_range(0, 2047) - 1024);
      return ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
   endfunction

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic feed(input int first, input int n, input int gapmax);
      for (int i = first; i < first + n; i++) begin
         int g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
         repeat (g) begin
            out_valid = 1'b0;
            @(negedge clk);
         end
         out_valid = 1'b1;
         out_data  = bo[i];
         target    = bt[i];
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; out_valid = 1'b0; out_data = '0; target = '0;
      repeat (2) @(negedge clk);
      tests++;
      if ({in_ready, S_Error, busy} !== 3'b000) begin
         fails++; $display("FAIL reset_flags got %b expected 000", {in_ready, S_Error, busy});
      end
      tests++;
      if (Error !== 16'h0000) begin fails++; $display("FAIL reset_error got %h expected 0000", Error); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int p0 = pulses;
      for (int i = 0; i < 4; i++) begin bo[i] = 16'h0200; bt[i] = 16'h0100; end
      pulse_start();
      tests++;
      if ({busy, in_ready} !== 2'b11) begin fails++; $display("FAIL basic_accum got %b expected 11", {busy, in_ready}); end
      feed(0, 4, 0);
      tests++;
      if (S_Error !== 1'b1) begin fails++; $display("FAIL basic_serr got %b expected 1", S_Error); end
      tests++;
      if (Error !== 16'h0400) begin fails++; $display("FAIL basic_error got %h expected 0400", Error); end
      out_valid = 1'b0;
      @(negedge clk);
      tests++;
      if ({S_Error, busy} !== 2'b00) begin fails++; $display("FAIL basic_idle got %b expected 00", {S_Error, busy}); end
      tests++;
      if (pulses - p0 != 1) begin fails++; $display("FAIL basic_pulses got %0d expected 1", pulses - p0); end
   endtask

   task automatic test_saturate();
      int p0 = pulses;
      for (int i = 0; i < 4; i++) begin bo[i] = 16'h7FFF; bt[i] = 16'h8000; end
      pulse_start();
      feed(0, 4, 0);
      tests++;
      if (Error !== 16'h7FFF || S_Error !== 1'b1) begin
         fails++; $display("FAIL sat_error got %h/%b expected 7fff/1", Error, S_Error);
      end
      out_valid = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (pulses - p0 != 1) begin fails++; $display("FAIL sat_pulses got %0d expected 1", pulses - p0); end
   endtask

   task automatic test_stall();
      logic [15:0] exp;
      for (int i = 0; i < 4; i++) begin bo[i] = 16'h0180; bt[i] = 16'h0100; end
`ifdef LOSS_UNIT_ABS_ERR_EN
      exp = 16'h0200;
`else
      exp = 16'h0100;
`endif
      pulse_start();
      feed(0, 2, 0);
      out_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++;
         if ({in_ready, busy, S_Error} !== 3'b110) begin
            fails++; $display("FAIL stall_cycle%0d got %b expected 110", c, {in_ready, busy, S_Error});
         end
      end
      feed(2, 2, 0);
      tests++;
      if (Error !== exp || Error !== model_err(0, 4) || S_Error !== 1'b1) begin
         fails++; $display("FAIL stall_error got %h/%b expected %h/1", Error, S_Error, exp);
      end
      out_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int p0;
      for (int i = 0; i < 4; i++) begin bo[i] = rnd_word(); bt[i] = bo[i]; end
      pulse_start();
      feed(0, 2, 0);
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({in_ready, S_Error, busy} !== 3'b000 || Error !== 16'h0000) begin
         fails++; $display("FAIL rstmid_outputs got %b/%h expected 000/0000", {in_ready, S_Error, busy}, Error);
      end
      out_valid = 1'b0;
      @(negedge clk) rst = 1'b0;
      p0 = pulses;
      repeat (4) @(negedge clk);
      tests++;
      if (pulses != p0 || busy !== 1'b0) begin
         fails++; $display("FAIL rstmid_no_pulse got %0d/%b expected 0/0", pulses - p0, busy);
      end
      pulse_start();
      feed(0, 4, 0);
      tests++;
      if (Error !== 16'h0000 || S_Error !== 1'b1) begin
         fails++; $display("FAIL rstmid_zero got %h/%b expected 0000/1", Error, S_Error);
      end
      out_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (pulses - p0 != 1) begin fails++; $display("FAIL rstmid_pulses got %0d expected 1", pulses - p0); end
   endtask

   task automatic test_restart();
      int p0 = pulses;
      logic [15:0] prev = Error;
      logic [15:0] exp;
      for (int i = 0; i < 3; i++) begin bo[i] = 16'h0300; bt[i] = 16'h0200; end
      for (int i = 3; i < 7; i++) begin bo[i] = 16'h0400; bt[i] = 16'h0200; end
`ifdef LOSS_UNIT_ABS_ERR_EN
      exp = 16'h0800;
`else
      exp = 16'h1000;
`endif
      pulse_start();
      feed(0, 3, 0);
      out_valid = 1'b0;
      pulse_start();
      tests++;
      if (in_ready !== 1'b1 || Error !== prev || pulses != p0) begin
         fails++; $display("FAIL restart_hold got %b/%h/%0d expected 1/%h/0", in_ready, Error, pulses - p0, prev);
      end
      feed(3, 4, 0);
      tests++;
      if (Error !== exp || Error !== model_err(3, 4)) begin
         fails++; $display("FAIL restart_error got %h expected %h", Error, exp);
      end
      out_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (pulses - p0 != 1) begin fails++; $display("FAIL restart_pulses got %0d expected 1", pulses - p0); end
   endtask

   task automatic test_idle_beats();
      int p0 = pulses;
      logic [15:0] prev = Error;
      for (int c = 0; c < 3; c++) begin
         out_valid = 1'b1; out_data = rnd_word(); target = rnd_word();
         @(negedge clk);
         tests++;
         if ({in_ready, busy, S_Error} !== 3'b000 || Error !== prev) begin
            fails++; $display("FAIL idle_ignore got %b/%h expected 000/%h", {in_ready, busy, S_Error}, Error, prev);
         end
      end
      out_valid = 1'b0;
      tests++;
      if (pulses != p0) begin fails++; $display("FAIL idle_pulses got %0d expected 0", pulses - p0); end
   endtask

   task automatic test_start_in_done();
      int p0 = pulses;
      logic [15:0] ea, eb;
      for (int i = 0; i < 8; i++) begin bo[i] = rnd_word(); bt[i] = rnd_word(); end
      ea = model_err(0, 4);
      eb = model_err(4, 4);
      pulse_start();
      feed(0, 4, 1);
      tests++;
      if (S_Error !== 1'b1 || Error !== ea) begin
         fails++; $display("FAIL done_first got %b/%h expected 1/%h", S_Error, Error, ea);
      end
      out_valid = 1'b0;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      tests++;
      if ({busy, in_ready, S_Error} !== 3'b110 || Error !== ea) begin
         fails++; $display("FAIL done_restart got %b/%h expected 110/%h", {busy, in_ready, S_Error}, Error, ea);
      end
      feed(4, 4, 1);
      tests++;
      if (S_Error !== 1'b1 || Error !== eb) begin
         fails++; $display("FAIL done_second got %b/%h expected 1/%h", S_Error, Error, eb);
      end
      out_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (pulses - p0 != 2) begin fails++; $display("FAIL done_pulses got %0d expected 2", pulses - p0); end
   endtask

   task automatic test_random();
      for (int s = 0; s < 25; s++) begin
         logic [15:0] exp;
         for (int i = 0; i < 4; i++) begin bo[i] = rnd_word(); bt[i] = rnd_word(); end
         exp = model_err(0, 4);
         pulse_start();
         feed(0, 4, 3);
         tests++;
         if (S_Error !== 1'b1 || Error !== exp) begin
            fails++; $display("FAIL random%0d got %b/%h expected 1/%h", s, S_Error, Error, exp);
         end
         out_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_stall();
      test_reset_mid();
      test_restart();
      test_idle_beats();
      test_start_in_done();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/loss_unit.md
LOSS_UNIT -- requirements
Module: loss_unit

Interface
REQ-001 Parameter BITS, default 16: width of sample data and Error.
REQ-002 Parameter FRAC, default 8: fractional bits of signed fixed-point data.
REQ-003 Parameter N_OUT, default 4: network outputs compared per sample.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a new sample's error computation (driven by the VL pulse of the training controller).
REQ-007 out_valid  input  1  out_data/target beat valid.
REQ-008 out_data  input  BITS  signed network output.
REQ-009 target  input  BITS  signed expected value.
REQ-010 in_ready  output  1  high while beats are accepted.
REQ-011 Error  output  BITS  unsigned per-sample error, saturated to 2^(BITS-1)-1.
REQ-012 S_Error  output  1  one-cycle pulse; Error valid (feeds the training controller).
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, ACCUM, DONE.
REQ-015 IDLE: start=1 -> ACCUM next cycle; accumulator and beat counter cleared to 0.
REQ-016 in_ready = (state == ACCUM); beat accepted when in_ready & out_valid.
REQ-017 Per beat: diff = out_data - target, computed at BITS+1 bits signed, no overflow.
REQ-018 Term = (diff*diff) >> FRAC, unsigned, product 2*BITS+2 bits, truncation toward zero.
REQ-019 Accumulator BITS+8 bits unsigned; adding term saturates at all-ones, sticky until cleared.
REQ-020 Counter increments per accepted beat; accepting beat N_OUT moves ACCUM -> DONE.
REQ-021 ACCUM with out_valid=0: hold state, no accumulation, no timeout.
REQ-022 Entering DONE: Error <= min(accumulator incl. final term, 2^(BITS-1)-1), registered.
REQ-023 DONE lasts exactly one cycle with S_Error=1, then IDLE; S_Error latency = 1 cycle after final accepted beat.
REQ-024 Error holds its value until the next DONE; unaffected by start.
REQ-025 start while in ACCUM: discard partial sum, clear counter, remain ACCUM (restart); no S_Error.
REQ-026 start in DONE: S_Error still pulses; next state ACCUM with cleared accumulator.
REQ-027 out_valid in IDLE or DONE: ignored.

Reset
REQ-028 rst=1 asynchronously forces: state IDLE, accumulator 0, counter 0, Error 0, S_Error 0, in_ready 0, busy 0.
REQ-029 rst mid-ACCUM aborts the sample; no S_Error produced for it after release.
REQ-030 First start accepted on the first rising edge with rst low.

Configuration
REQ-031 Macro LOSS_UNIT_ABS_ERR_EN defined: term = |diff| (BITS+1 bits, no shift); squaring logic absent.
REQ-032 Macro undefined: term per REQ-018 (squared error); all other behaviour identical.

Verification (BITS=16, FRAC=8, N_OUT=4, macro undefined unless stated)
REQ-033 start, 4 beats out_data=0x0200 target=0x0100 back-to-back -> S_Error high 1 cycle after 4th beat, Error=0x0400.
REQ-034 4 beats out_data=0x7FFF target=0x8000 -> Error=0x7FFF (saturated), S_Error single pulse.
REQ-035 2 beats accepted, out_valid low 5 cycles, 2 more beats (diff 0x0080 each) -> Error=0x0100, in_ready high throughout ACCUM.
REQ-036 rst asserted after 2 beats -> all outputs 0 immediately; new start + 4 zero-diff beats -> Error=0x0000, one S_Error.
REQ-037 start reissued after 3 beats of diff 0x0100, then 4 beats diff 0x0200 -> Error=0x1000, exactly one S_Error.
REQ-038 LOSS_UNIT_ABS_ERR_EN defined, 4 beats out_data=0x0100 target=0x0300 -> Error=0x0800.
